// File: rtl/riscv_pkg.sv
// Definitions shared across the RV32I core: datapath width, NOP encoding,
// fetch FSM state type, and the opcode map used by decode/control.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [2:0] instr_funct3(input logic [31:0] instr);
      return instr[14:12];
   endfunction

   function automatic logic [6:0] instr_funct7(input logic [31:0] instr);
      return instr[31:25];
   endfunction

endpackage

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, single-outstanding imem requests,
// one-entry output buffer to decode, and redirect with wrong-path discard.
module fetch_stage #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [31:0]     if_instr
);

   riscv_pkg::fetch_state_t state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic            buf_valid_q, buf_valid_d;
   logic [XLEN-1:0] buf_pc_q, buf_pc_d;
   logic [31:0]     buf_instr_q, buf_instr_d;

   logic            req_fire;
   logic            xfer;
   logic [XLEN-1:0] redirect_tgt;
   logic            unused_redirect_lsb;

   assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // Gated by rst_n so nothing is requested while reset is held.
   assign imem_req_valid = rst_n & (state_q == riscv_pkg::REQ) & (~buf_valid_q | if_ready);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   assign if_valid = buf_valid_q & ~redirect_valid;
   assign if_pc    = buf_pc_q;
   assign if_instr = buf_instr_q;
   assign xfer     = if_valid & if_ready;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;

      if (redirect_valid) begin
         pc_d        = redirect_tgt;
         buf_valid_d = 1'b0;
         case (state_q)
            riscv_pkg::REQ: begin
               if (req_fire) begin
                  req_pc_d = pc_q;
                  state_d  = riscv_pkg::DROP;
               end
            end
            riscv_pkg::WAIT: state_d = imem_rsp_valid ? riscv_pkg::REQ : riscv_pkg::DROP;
            riscv_pkg::DROP: state_d = imem_rsp_valid ? riscv_pkg::REQ : riscv_pkg::DROP;
            default:         state_d = riscv_pkg::REQ;
         endcase
      end else begin
         if (xfer) begin
            buf_valid_d = 1'b0;
         end
         case (state_q)
            riscv_pkg::REQ: begin
               if (req_fire) begin
                  req_pc_d = pc_q;
                  state_d  = riscv_pkg::WAIT;
               end
            end
            riscv_pkg::WAIT: begin
               // Buffer is guaranteed empty or draining here, so loading never overwrites.
               if (imem_rsp_valid) begin
                  buf_valid_d = 1'b1;
                  buf_pc_d    = req_pc_q;
                  buf_instr_d = imem_rsp_data;
                  pc_d        = req_pc_q + XLEN'(4);
                  state_d     = riscv_pkg::REQ;
               end
            end
            riscv_pkg::DROP: begin
               if (imem_rsp_valid) begin
                  state_d = riscv_pkg::REQ;
               end
            end
            default: state_d = riscv_pkg::REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= riscv_pkg::REQ;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= riscv_pkg::NOP_INSTR;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
      end
   end

endmodule
